// File: rtl/sccb_target_responder_pkg.sv
// Shared definitions for the SCCB target responder: FSM state encodings,
// transfer direction bit values and the default OV7670 device address.
package sccb_target_responder_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ID        = 4'd1,
        ST_ID_ACK    = 4'd2,
        ST_SUB       = 4'd3,
        ST_SUB_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_NA  = 4'd8,
        ST_IGNORE    = 4'd9
    } sccb_state_e;

    localparam logic       SCCB_WRITE  = 1'b0;
    localparam logic       SCCB_READ   = 1'b1;
    localparam logic [6:0] OV7670_ADDR = 7'h21;

    // The upper seven bits of an ID byte carry the target address.
    function automatic logic addr_match(input logic [7:0] id_byte, input logic [6:0] dev_addr);
        return (id_byte[7:1] == dev_addr);
    endfunction

endpackage

// File: rtl/sccb_target_responder_line_sync.sv
// Synchronizes SIOC/SIOD into the system clock domain and flags clock edges
// plus START/STOP conditions; every output is registered.
module sccb_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic scl_q_s, sda_q_s;
    logic scl_r, sda_r, scl_rise_r, scl_fall_r, start_det_r, stop_det_r;

    assign scl_q_s = scl_sync_r[SYNC_STAGES-1];
    assign sda_q_s = sda_sync_r[SYNC_STAGES-1];

    // Sync chains idle high so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_r  <= '1;
            sda_sync_r  <= '1;
            scl_r       <= 1'b1;
            sda_r       <= 1'b1;
            scl_rise_r  <= 1'b0;
            scl_fall_r  <= 1'b0;
            start_det_r <= 1'b0;
            stop_det_r  <= 1'b0;
        end else begin
            scl_sync_r  <= {scl_sync_r[SYNC_STAGES-2:0], scl_in};
            sda_sync_r  <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
            scl_r       <= scl_q_s;
            sda_r       <= sda_q_s;
            scl_rise_r  <= scl_q_s & ~scl_r;
            scl_fall_r  <= ~scl_q_s & scl_r;
            start_det_r <= scl_q_s & scl_r & sda_r & ~sda_q_s;
            stop_det_r  <= scl_q_s & scl_r & ~sda_r & sda_q_s;
        end
    end

    assign scl       = scl_r;
    assign sda       = sda_r;
    assign scl_rise  = scl_rise_r;
    assign scl_fall  = scl_fall_r;
    assign start_det = start_det_r;
    assign stop_det  = stop_det_r;

endmodule

// File: rtl/sccb_target_responder.sv
// SCCB target emulating the OV7670 configuration port: decodes ID, sub-address
// and data phases and drives an external 8x256 register file via strobes.
module sccb_target_responder
    import sccb_target_responder_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR = OV7670_ADDR,
    parameter bit         ACK_ENABLE  = 1'b1,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       GLOBAL_CLK,
    input  logic       RESET,
    input  logic       SIOC,
    input  logic       SIOD_IN,
    output logic       SIOD_OE,
    output logic [7:0] REG_ADDR,
    output logic [7:0] REG_WDATA,
    output logic       REG_WE,
    output logic       REG_RD,
    input  logic [7:0] REG_RDATA,
    output logic       BUSY
);

    logic scl_s, sda_s, scl_rise_s, scl_fall_s, start_det_s, stop_det_s;
    logic start_v_s, stop_v_s;

    sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clk       (GLOBAL_CLK),
        .rst       (RESET),
        .scl_in    (SIOC),
        .sda_in    (SIOD_IN),
        .scl       (scl_s),
        .sda       (sda_s),
        .scl_rise  (scl_rise_s),
        .scl_fall  (scl_fall_s),
        .start_det (start_det_s),
        .stop_det  (stop_det_s)
    );

    sccb_state_e state_r, state_s;
    logic [2:0]  cnt_r, cnt_s;
    logic [7:0]  shift_r, shift_s, byte_s;
    logic [7:0]  addr_r, addr_s, wdata_r, wdata_s;
    logic        oe_r, oe_s, we_r, we_s, rd_r, rd_s, rw_r, rw_s, busy_r, busy_s;

    // Our own low on SIOD must never be mistaken for a bus condition.
    assign start_v_s = start_det_s & scl_s & ~oe_r;
    assign stop_v_s  = stop_det_s & scl_s & ~oe_r;
    assign byte_s    = {shift_r[6:0], sda_s};

    // Next-state, shift/count and strobe decode.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        shift_s = shift_r;
        addr_s  = addr_r;
        wdata_s = wdata_r;
        oe_s    = oe_r;
        rw_s    = rw_r;
        busy_s  = busy_r;
        we_s    = 1'b0;
        rd_s    = 1'b0;
        if (stop_v_s) begin
            state_s = ST_IDLE;
            cnt_s   = 3'd0;
            oe_s    = 1'b0;
            busy_s  = 1'b0;
        end else if (start_v_s) begin
            state_s = ST_ID;
            cnt_s   = 3'd0;
            oe_s    = 1'b0;
        end else begin
            if (rd_r) begin
                shift_s = REG_RDATA;
            end else begin
                shift_s = shift_r;
            end
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_ID, ST_SUB, ST_WDATA: begin
                    if (scl_rise_s) begin
                        shift_s = byte_s;
                        cnt_s   = cnt_r + 3'd1;
                        if (cnt_r == 3'd7) begin
                            if (state_r == ST_ID) begin
                                if (addr_match(byte_s, DEVICE_ADDR)) begin
                                    rw_s    = byte_s[0];
                                    rd_s    = (byte_s[0] == SCCB_READ);
                                    busy_s  = 1'b1;
                                    state_s = ST_ID_ACK;
                                end else begin
                                    busy_s  = 1'b0;
                                    state_s = ST_IGNORE;
                                end
                            end else if (state_r == ST_SUB) begin
                                addr_s  = byte_s;
                                state_s = ST_SUB_ACK;
                            end else begin
                                wdata_s = byte_s;
                                we_s    = 1'b1;
                                state_s = ST_WDATA_ACK;
                            end
                        end else begin
                            state_s = state_r;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                // Ack slot: first fall claims the line, second fall leaves it.
                ST_ID_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
                    if (scl_fall_s) begin
                        if (cnt_r == 3'd0) begin
                            cnt_s = 3'd1;
                            oe_s  = ACK_ENABLE;
                        end else begin
                            cnt_s = 3'd0;
                            oe_s  = 1'b0;
                            if (state_r == ST_ID_ACK) begin
                                if (rw_r == SCCB_READ) begin
                                    state_s = ST_RDATA;
                                    oe_s    = ~shift_r[7];
                                end else begin
                                    state_s = ST_SUB;
                                end
                            end else if (state_r == ST_SUB_ACK) begin
                                state_s = ST_WDATA;
                            end else begin
                                state_s = ST_IGNORE;
                            end
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise_s) begin
                        cnt_s = cnt_r + 3'd1;
                        if (cnt_r == 3'd7) begin
                            state_s = ST_RDATA_NA;
                        end else begin
                            state_s = ST_RDATA;
                        end
                    end else if (scl_fall_s) begin
                        shift_s = {shift_r[6:0], 1'b0};
                        oe_s    = ~shift_r[6];
                    end else begin
                        state_s = ST_RDATA;
                    end
                end
                ST_RDATA_NA: begin
                    if (scl_fall_s) begin
                        oe_s    = 1'b0;
                        state_s = ST_IGNORE;
                    end else begin
                        state_s = ST_RDATA_NA;
                    end
                end
                ST_IGNORE: begin
                    state_s = ST_IGNORE;
                end
                default: begin
                    state_s = ST_IDLE;
                    oe_s    = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge GLOBAL_CLK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
            shift_r <= 8'h00;
            addr_r  <= 8'h00;
            wdata_r <= 8'h00;
            oe_r    <= 1'b0;
            we_r    <= 1'b0;
            rd_r    <= 1'b0;
            rw_r    <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            shift_r <= shift_s;
            addr_r  <= addr_s;
            wdata_r <= wdata_s;
            oe_r    <= oe_s;
            we_r    <= we_s;
            rd_r    <= rd_s;
            rw_r    <= rw_s;
            busy_r  <= busy_s;
        end
    end

    assign SIOD_OE   = oe_r;
    assign REG_ADDR  = addr_r;
    assign REG_WDATA = wdata_r;
    assign REG_WE    = we_r;
    assign REG_RD    = rd_r;
    assign BUSY      = busy_r;

endmodule
